// File: rtl/rr_mux.sv
// rr_mux: N-input, W-bit arbitrated merge point with one registered output stage.
// Selection is round-robin (MODE 0) or fixed lowest-index priority (MODE 1).
module rr_mux #(
   parameter int unsigned W    = 32,
   parameter int unsigned N    = 4,
   parameter int unsigned MODE = 0,
   localparam int unsigned SW  = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N*W-1:0]   in_data,
   input  logic [N-1:0]     in_valid,
   output logic [N-1:0]     in_ready,
   output logic [W-1:0]     out_data,
   output logic [SW-1:0]    out_sel,
   output logic             out_valid,
   input  logic             out_ready
);

   logic [SW-1:0] ptr;
   logic [N-1:0]  mask_c;
   logic [N-1:0]  hi_c;
   logic [N-1:0]  pool_c;
   logic [N-1:0]  grant_c;
   logic [SW-1:0] gidx_c;
   logic [SW-1:0] ptr_nxt_c;
   logic [W-1:0]  sel_data_c;
   logic          any_c;
   logic          load_c;

   // Output register can take a word when empty or being drained this cycle.
   assign load_c = ~out_valid | out_ready;
   assign any_c  = |in_valid;

   // Grant: lowest requester at or above ptr, else wrap to lowest requester overall.
   // In fixed-priority mode the mask is empty, so this reduces to lowest index.
   always_comb begin
      mask_c  = '0;
      grant_c = '0;
      gidx_c  = '0;
      for (int unsigned i = 0; i < N; i++) begin
         mask_c[i] = (MODE == 0) && (SW'(i) >= ptr);
      end
      hi_c   = in_valid & mask_c;
      pool_c = (|hi_c) ? hi_c : in_valid;
      for (int unsigned i = 0; i < N; i++) begin
         if (pool_c[i] && (grant_c == '0)) begin
            grant_c[i] = 1'b1;
            gidx_c     = SW'(i);
         end
      end
   end

   // One-hot AND-OR select of the granted channel's word.
   always_comb begin
      sel_data_c = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (grant_c[i]) begin
            sel_data_c = in_data[i*W +: W];
         end
      end
   end

   // Next pointer: one past the granted channel, wrapping after N-1; fixed priority keeps 0.
   always_comb begin
      ptr_nxt_c = '0;
      if (MODE == 0) begin
         ptr_nxt_c = (gidx_c == SW'(N - 1)) ? '0 : gidx_c + SW'(1);
      end
   end

   // Handshake back to the requesters; nothing is accepted while in reset.
   assign in_ready = grant_c & {N{load_c & ~rst}};

   // Output stage and arbitration pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data  <= '0;
         out_sel   <= '0;
         out_valid <= 1'b0;
         ptr       <= '0;
      end else if (load_c) begin
         out_valid <= any_c;
         if (any_c) begin
            out_data <= sel_data_c;
            out_sel  <= gidx_c;
            ptr      <= ptr_nxt_c;
         end
      end
   end

endmodule

// File: doc/rr_mux.md
# rr_mux

Parametrised N-input, W-bit arbitrated multiplexer with a registered output and valid/ready handshakes on every channel. It generalises the CPU's two-input combinational select into a sequential merge point for multiple requesters, such as the instruction-fetch, load/store and debug ports contending for one memory or bus port. Selection is round-robin or fixed-priority, set by a parameter.

## Interface
- W, 32, data width per channel (≥1)
- N, 4, number of input channels (≥1)
- MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
- SW, derived, select width = (N>1) ? $clog2(N) : 1; not to be overridden

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_data  in  N*W  channel i occupies bits [i*W +: W]
- in_valid  in  N  channel i presents a word
- in_ready  out  N  channel i word accepted this cycle when in_valid[i] & in_ready[i]
- out_data  out  W  registered selected word
- out_sel  out  SW  index of the channel that supplied out_data
- out_valid  out  1  out_data/out_sel hold a word
- out_ready  in  1  downstream accepts when out_valid & out_ready

## Operation
- One output register holding data, sel and valid; no other data storage.
- load = ~out_valid | out_ready; the register can take a new word this cycle.
- Request vector req = in_valid. Grant is one-hot, combinational from req and the priority pointer ptr (SW bits):
  - MODE 0: first set bit of req scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - MODE 1: lowest-index set bit of req; ptr is ignored and held at 0.
- in_ready[i] = grant[i] & load. At most one in_ready bit is high. in_ready is 0 for all channels when req == 0.
- On accept of channel g: out_data <= in_data[g], out_sel <= g, out_valid <= 1; MODE 0: ptr <= (g == N-1) ? 0 : g+1.
- On a drain (out_valid & out_ready) with no accept: out_valid <= 0. out_data and out_sel hold their last values.
- Drain and accept in the same cycle: the register takes the new word and out_valid stays 1. Sustained throughput is 1 word/cycle.
- Backpressure (out_valid & ~out_ready): out_data, out_sel and out_valid are held stable, all in_ready are 0, and ptr is held.
- ptr changes only on an accept.
- Inputs may change or drop in_valid when not accepted; the grant re-evaluates every cycle. There is no lock to a channel.
- N=1: grant = in_valid[0], out_sel is always 0, ptr is always 0.

## Timing
- Reset (async assert, sync deassert expected from upstream): out_valid=0, out_data=0, out_sel=0, ptr=0. in_ready follows combinationally: all 0 while rst is high.
- Latency: a word accepted at edge k is visible on out_data with out_valid=1 after edge k.
- in_ready depends combinationally on in_valid and out_ready. in_valid must not depend combinationally on in_ready.
- Reset mid-operation: a held output word is discarded and out_valid drops immediately. Arbitration restarts with channel 0 at top priority.
- ptr wrap-around: an accept from channel N-1 sets ptr to 0.
- Round-robin fairness: with all N requesting continuously and out_ready=1, each channel is granted exactly once every N cycles.

## Test plan
- Reset: assert rst mid-run while out_valid=1 and out_data=32'hcafebabe -> out_valid=0, out_data=0, out_sel=0 immediately; after release with all valid, the first grant is channel 0.
- Round-robin, N=4, W=32, MODE 0: in_data = {32'hdddd0003, 32'hcccc0002, 32'hbbbb0001, 32'haaaa0000}, all valid, out_ready=1 -> out_sel sequence 0,1,2,3,0,… with matching data at one word/cycle; the 0 after 3 shows the pointer wrap.
- Sparse requests: only channels 1 and 3 valid, ptr=2 -> grant 3, then 1, then 3 (skips idle channels).
- Backpressure: out_ready=0 for 5 cycles with out_data=32'hdeadbeef -> out_data, out_sel and out_valid stable and in_ready=0 throughout. On release, that word drains and the next granted word loads in the same cycle.
- Fixed priority, MODE 1: channels 0 and 2 continuously valid -> channel 0 granted every cycle. Drop in_valid[0] -> channel 2 granted the next cycle.
- N=1 and N=2: single channel passes through with out_sel=0; N=2 alternates 0,1 under full load. Idle input (no valid) -> out_valid falls to 0 after a drain, out_data holds its last value.
